// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/MRET sequencer driving the CSR port and fetch redirect.
// Define TRAP_VECTORED_EN to vector interrupts through mtvec when mtvec[1:0] == 2'b01.
module trap_ctrl #(
  parameter int XLEN = 32,
  parameter int CSR_AW = 32,
  parameter logic [CSR_AW-1:0] MSTATUS_ADDR = 'h300,
  parameter logic [CSR_AW-1:0] MTVEC_ADDR = 'h305,
  parameter logic [CSR_AW-1:0] MEPC_ADDR = 'h341,
  parameter logic [CSR_AW-1:0] MCAUSE_ADDR = 'h342
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exc_req_i,
  input  logic [XLEN-1:0]   exc_cause_i,
  input  logic [XLEN-1:0]   exc_pc_i,
  input  logic              mret_req_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              csr_we_o,
  output logic              csr_re_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i
);
  typedef enum logic [3:0] {
    IDLE, W_EPC, W_CAUSE, R_STAT, WAIT_STAT, W_STAT, R_TVEC, WAIT_TVEC, REDIRECT, R_EPC, WAIT_EPC
  } state_t;
  state_t state, state_nxt;
  logic mret_q;
  logic [XLEN-1:0] cause_q, pc_q, stat_q, epc_q, rpc_q, target, stat_exc, stat_mret;
`ifdef TRAP_VECTORED_EN
  assign target = {csr_rdata_i[XLEN-1:2], 2'b00} +
                  ((csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1]) ? {cause_q[XLEN-3:0], 2'b00} : '0);
`else
  assign target = {csr_rdata_i[XLEN-1:2], 2'b00};
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = exc_req_i ? W_EPC : mret_req_i ? R_EPC : IDLE;
      W_EPC:     state_nxt = W_CAUSE;
      W_CAUSE:   state_nxt = R_STAT;
      R_STAT:    state_nxt = WAIT_STAT;
      WAIT_STAT: state_nxt = W_STAT;
      W_STAT:    state_nxt = mret_q ? REDIRECT : R_TVEC;
      R_TVEC:    state_nxt = WAIT_TVEC;
      WAIT_TVEC: state_nxt = REDIRECT;
      R_EPC:     state_nxt = WAIT_EPC;
      WAIT_EPC:  state_nxt = R_STAT;
      default:   state_nxt = IDLE;
    endcase
  end
  // The fetch target is resolved on the edge entering REDIRECT and then held.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mret_q <= 1'b0;
      cause_q <= '0;
      pc_q <= '0;
      stat_q <= '0;
      epc_q <= '0;
      rpc_q <= '0;
    end else begin
      if (state == IDLE) mret_q <= !exc_req_i && mret_req_i;
      if (state == IDLE && exc_req_i) begin
        cause_q <= exc_cause_i;
        pc_q <= exc_pc_i;
      end
      if (state == WAIT_STAT) stat_q <= csr_rdata_i;
      if (state == WAIT_EPC) epc_q <= csr_rdata_i;
      if (state == WAIT_TVEC) rpc_q <= target;
      if (state == W_STAT && mret_q) rpc_q <= epc_q;
    end
  always_comb begin
    stat_exc = stat_q;
    stat_exc[7] = stat_q[3];
    stat_exc[3] = 1'b0;
    stat_exc[12:11] = 2'b11;
    stat_mret = stat_q;
    stat_mret[3] = stat_q[7];
    stat_mret[7] = 1'b1;
    stat_mret[12:11] = 2'b11;
    csr_we_o = state inside {W_EPC, W_CAUSE, W_STAT};
    csr_re_o = state inside {R_STAT, R_TVEC, R_EPC};
    csr_addr_o = (state == W_EPC || state == R_EPC) ? MEPC_ADDR :
                 state == W_CAUSE ? MCAUSE_ADDR :
                 (state == R_STAT || state == W_STAT) ? MSTATUS_ADDR :
                 state == R_TVEC ? MTVEC_ADDR : '0;
    csr_wdata_o = state == W_EPC ? {pc_q[XLEN-1:2], 2'b00} :
                  state == W_CAUSE ? cause_q :
                  state == W_STAT ? (mret_q ? stat_mret : stat_exc) : '0;
    busy_o = state != IDLE;
    done_o = state == REDIRECT;
    redirect_valid_o = state == REDIRECT;
    redirect_pc_o = rpc_q;
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: vector table, hand-written corner sequences and random traps against a CSR-file model.
module tb_trap_ctrl;
  logic clk_i = 0, rst_i = 0, exc_req_i = 0, mret_req_i = 0;
  logic [31:0] exc_cause_i = 0, exc_pc_i = 0, csr_rdata_i = 0;
  logic busy_o, done_o, redirect_valid_o, csr_we_o, csr_re_o;
  logic [31:0] redirect_pc_o, csr_addr_o, csr_wdata_o;
  int n_tests = 0, n_fail = 0;
  always #5 clk_i = ~clk_i;
  trap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .exc_req_i(exc_req_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .mret_req_i(mret_req_i), .busy_o(busy_o), .done_o(done_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .csr_addr_o(csr_addr_o),
    .csr_we_o(csr_we_o), .csr_re_o(csr_re_o), .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i)
  );
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VEC_PC = 32'h21C, VEC_WRAP = 32'hFFFF_FFEC;
`else
  localparam logic [31:0] VEC_PC = 32'h200, VEC_WRAP = 32'hFFFF_FFF0;
`endif
  logic clr = 0;
  logic [31:0] cfg_stat = 0, cfg_tvec = 0, cfg_epc = 0;
  logic [31:0] w_epc = 0, w_cause = 0, w_stat = 0, first_addr = '1;
  int n_wr = 0, n_rd = 0, n_redir = 0, n_done = 0, n_bad = 0;
  // CSR file: read data returned one cycle after the strobe, noise otherwise
  always @(posedge clk_i) begin
    csr_rdata_i <= !csr_re_o ? $urandom : csr_addr_o == 32'h300 ? cfg_stat :
                   csr_addr_o == 32'h305 ? cfg_tvec : csr_addr_o == 32'h341 ? cfg_epc : 32'hBAD0_BAD0;
    if (clr) begin
      n_wr <= 0;
      n_rd <= 0;
      first_addr <= '1;
    end else begin
      if (csr_we_o) begin
        n_wr <= n_wr + 1;
        if (csr_addr_o == 32'h341) w_epc <= csr_wdata_o;
        if (csr_addr_o == 32'h342) w_cause <= csr_wdata_o;
        if (csr_addr_o == 32'h300) w_stat <= csr_wdata_o;
      end
      if (csr_re_o) n_rd <= n_rd + 1;
      if ((csr_we_o || csr_re_o) && first_addr == '1) first_addr <= {csr_we_o, csr_addr_o[30:0]};
    end
  end
  always @(negedge clk_i) begin
    if (clr) begin
      n_redir <= 0;
      n_done <= 0;
    end else begin
      if (redirect_valid_o) n_redir <= n_redir + 1;
      if (done_o) n_done <= n_done + 1;
    end
    if ((csr_we_o && csr_re_o) || (!csr_we_o && !csr_re_o && (csr_addr_o != 0 || csr_wdata_o != 0))
        || (done_o != redirect_valid_o)) n_bad <= n_bad + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  task automatic clear();
    clr = 1;
    tick();
    clr = 0;
  endtask
  function automatic logic [31:0] m_exc_stat(input logic [31:0] s);
    logic [31:0] mie = (s >> 3) & 32'd1;
    return (s & ~32'h1888) | (mie << 7) | (32'd3 << 11);
  endfunction
  function automatic logic [31:0] m_mret_stat(input logic [31:0] s);
    logic [31:0] mpie = (s >> 7) & 32'd1;
    return (s & ~32'h1888) | (mpie << 3) | (32'd1 << 7) | (32'd3 << 11);
  endfunction
  function automatic logic [31:0] m_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base = tvec & ~32'd3;
`ifdef TRAP_VECTORED_EN
    if ((tvec & 32'd3) == 32'd1 && cause >= 32'h8000_0000) base = base + (cause & 32'h7FFF_FFFF) * 4;
`endif
    return base;
  endfunction
  // Raises the request(s), returns cycles from the accepting edge to redirect (0 on timeout).
  task automatic go(input logic e, input logic m, output int lat);
    exc_req_i = e;
    mret_req_i = m;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) begin
        exc_cause_i = $urandom;
        exc_pc_i = $urandom;
      end
      if (redirect_valid_o) begin
        lat = n;
        break;
      end
    end
    exc_req_i = 0;
    mret_req_i = 0;
  endtask
  task automatic run_case(input string nm, input logic m, input logic [31:0] cause, pc, stat, tvec,
                          epc, exp_pc, exp_stat, input int exp_lat);
    int lat;
    cfg_stat = stat;
    cfg_tvec = tvec;
    cfg_epc = epc;
    clear();
    exc_cause_i = cause;
    exc_pc_i = pc;
    go(!m, m, lat);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " redirect_pc"}, redirect_pc_o, exp_pc);
    tick();
    chk({nm, " pulse width"}, {31'd0, redirect_valid_o}, 0);
    chk({nm, " busy after"}, {31'd0, busy_o}, 0);
    chk({nm, " redirect_pc held"}, redirect_pc_o, exp_pc);
    chk({nm, " mstatus write"}, w_stat, exp_stat);
    chk({nm, " redirect count"}, 32'(n_redir), 1);
    chk({nm, " done count"}, 32'(n_done), 1);
    chk({nm, " reads"}, 32'(n_rd), 2);
    chk({nm, " writes"}, 32'(n_wr), m ? 1 : 3);
    if (!m) begin
      chk({nm, " mepc write"}, w_epc, pc & ~32'd3);
      chk({nm, " mcause write"}, w_cause, cause);
    end
  endtask
  typedef struct {
    logic m;
    logic [31:0] cause, pc, stat, tvec, epc, exp_pc, exp_stat;
    int lat;
  } vec_t;
  vec_t tbl[7];
  initial begin
    int lat;
    tbl[0] = '{1'b0, 32'd2, 32'h1004, 32'h8, 32'h100, 32'h0, 32'h100, 32'h1880, 8};
    tbl[1] = '{1'b1, 32'd0, 32'h0, 32'h1880, 32'h0, 32'h1004, 32'h1004, 32'h1888, 6};
    tbl[2] = '{1'b0, 32'h8000_0007, 32'h2003, 32'h0, 32'h201, 32'h0, VEC_PC, 32'h1800, 8};
    tbl[3] = '{1'b0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF7, 8};
    tbl[4] = '{1'b1, 32'd0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1880, 6};
    tbl[5] = '{1'b1, 32'd0, 32'h0, 32'hFFFF_FF7F, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF7, 6};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF, 32'h10, 32'h8, 32'hFFFF_FFF1, 32'h0, VEC_WRAP, 32'h1880, 8};
    #1 rst_i = 1;
    tick();
    tick();
    chk("reset busy", {31'd0, busy_o}, 0);
    chk("reset strobes", {28'd0, csr_we_o, csr_re_o, done_o, redirect_valid_o}, 0);
    chk("reset addr", csr_addr_o, 0);
    chk("reset redirect_pc", redirect_pc_o, 0);
    rst_i = 0;
    tick();
    foreach (tbl[i])
      run_case($sformatf("vec%0d", i), tbl[i].m, tbl[i].cause, tbl[i].pc, tbl[i].stat, tbl[i].tvec,
               tbl[i].epc, tbl[i].exp_pc, tbl[i].exp_stat, tbl[i].lat);
    // both requests on one edge: exception first, held MRET taken in the following IDLE cycle
    cfg_stat = 32'h8;
    cfg_tvec = 32'h40;
    cfg_epc = 32'h3000;
    clear();
    exc_cause_i = 32'd1;
    exc_pc_i = 32'h80;
    exc_req_i = 1;
    mret_req_i = 1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (redirect_valid_o) begin
        lat = n;
        break;
      end
    end
    chk("prio exc latency", 32'(lat), 8);
    chk("prio first strobe", first_addr, 32'h8000_0341);
    chk("prio exc target", redirect_pc_o, 32'h40);
    exc_req_i = 0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (redirect_valid_o) begin
        lat = n;
        break;
      end
    end
    mret_req_i = 0;
    chk("prio mret latency", 32'(lat), 7);
    chk("prio mret target", redirect_pc_o, 32'h3000);
    chk("prio mret mstatus", w_stat, m_mret_stat(32'h8));
    tick();
    chk("prio redirect count", 32'(n_redir), 2);
    // reset while waiting on mstatus read data
    clear();
    exc_cause_i = 32'd3;
    exc_pc_i = 32'h400;
    exc_req_i = 1;
    repeat (4) tick();
    chk("abort busy before", {31'd0, busy_o}, 1);
    #1 rst_i = 1;
    #1;
    chk("abort busy", {31'd0, busy_o}, 0);
    chk("abort strobes", {28'd0, csr_we_o, csr_re_o, done_o, redirect_valid_o}, 0);
    chk("abort addr", csr_addr_o, 0);
    chk("abort redirect_pc", redirect_pc_o, 0);
    exc_req_i = 0;
    tick();
    tick();
    rst_i = 0;
    repeat (3) tick();
    chk("abort writes", 32'(n_wr), 2);
    chk("abort reads", 32'(n_rd), 1);
    chk("abort no redirect", 32'(n_redir), 0);
    run_case("after abort", 1'b0, 32'd11, 32'h1234_5678, 32'h8, 32'h800, 32'h0, 32'h800, 32'h1880, 8);
    // second request pulse while busy is ignored
    cfg_stat = 32'h0;
    cfg_tvec = 32'h600;
    clear();
    exc_req_i = 1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) exc_req_i = 0;
      if (n == 3) begin
        exc_req_i = 1;
        mret_req_i = 1;
      end
      if (n == 5) begin
        exc_req_i = 0;
        mret_req_i = 0;
      end
      if (redirect_valid_o) begin
        lat = n;
        break;
      end
    end
    repeat (4) tick();
    chk("ignore latency", 32'(lat), 8);
    chk("ignore redirect count", 32'(n_redir), 1);
    chk("ignore done count", 32'(n_done), 1);
    chk("ignore busy", {31'd0, busy_o}, 0);
    for (int k = 0; k < 40; k++) begin
      logic m;
      logic [31:0] cause, pc, stat, tvec, epc;
      m = 1'($urandom_range(0, 1));
      cause = $urandom;
      pc = $urandom;
      stat = $urandom;
      epc = $urandom;
      tvec = $urandom;
      if ($urandom_range(0, 1) == 1) tvec = (tvec & ~32'd3) | 32'd1;
      run_case($sformatf("rand%0d", k), m, cause, pc, stat, tvec, epc,
               m ? epc : m_target(tvec, cause), m ? m_mret_stat(stat) : m_exc_stat(stat), m ? 6 : 8);
    end
    chk("port invariants", 32'(n_bad), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer that sits directly upstream of the CSR register file and drives its address/read/write port. On an exception or interrupt it saves mepc and mcause, updates mstatus, reads mtvec, and issues a PC redirect to fetch. On MRET it restores mstatus from mepc/mstatus and redirects to mepc. The core pipeline stalls on busy_o.

Parameters:
XLEN, 32, data width of CSR values and PCs
CSR_AW, 32, width of the CSR address bus
MSTATUS_ADDR, 32'h300, mstatus address
MTVEC_ADDR, 32'h305, mtvec address
MEPC_ADDR, 32'h341, mepc address
MCAUSE_ADDR, 32'h342, mcause address

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
exc_req_i  in  1  exception/interrupt request, level; sampled only in IDLE
exc_cause_i  in  XLEN  cause code; bit 31 = interrupt
exc_pc_i  in  XLEN  PC of faulting instruction
mret_req_i  in  1  MRET request, level; sampled only in IDLE
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse in the REDIRECT cycle
redirect_valid_o  out  1  redirect_pc_o valid (one cycle)
redirect_pc_o  out  XLEN  new fetch PC
csr_addr_o  out  CSR_AW  CSR address
csr_we_o  out  1  CSR write strobe
csr_re_o  out  1  CSR read strobe
csr_wdata_o  out  XLEN  CSR write data
csr_rdata_i  in  XLEN  CSR read data; valid the cycle after csr_re_o

Behaviour:
- Reset: state = IDLE; all outputs 0; internal cause/pc/mstatus latches 0. Asserting rst_i mid-sequence aborts immediately with no further CSR strobes.
- IDLE: busy_o = 0. On an edge with exc_req_i = 1, latch cause and PC, then go to W_EPC. Otherwise, if mret_req_i = 1, go to R_EPC. exc_req_i has priority when both are high.
- Exception path, one state per cycle, busy_o = 1 throughout:
  - W_EPC: addr = MEPC, we = 1, wdata = {pc[31:2], 2'b00}.
  - W_CAUSE: addr = MCAUSE, we = 1, wdata = cause.
  - R_STAT: addr = MSTATUS, re = 1.
  - WAIT_STAT: latch csr_rdata_i.
  - W_STAT: addr = MSTATUS, we = 1, wdata = stat with bit7 (MPIE) = old bit3 (MIE), bit3 = 0, bits[12:11] (MPP) = 2'b11, all other bits unchanged.
  - R_TVEC: addr = MTVEC, re = 1.
  - WAIT_TVEC: latch mtvec.
  - REDIRECT: redirect_valid_o = 1, done_o = 1, redirect_pc_o = target. Next state IDLE.
- Exception latency: redirect_valid_o is high exactly 8 cycles after the accepting edge.
- MRET path:
  - R_EPC: re = 1.
  - WAIT_EPC: latch epc.
  - R_STAT: re = 1.
  - WAIT_STAT: latch stat.
  - W_STAT: wdata = stat with bit3 = old bit7, bit7 = 1, MPP = 2'b11.
  - REDIRECT: redirect_pc_o = epc.
  - Latency: 6 cycles.
- csr_we_o and csr_re_o are never both high. csr_addr_o and csr_wdata_o are 0 when no strobe is active.
- redirect_pc_o holds its value after REDIRECT until the next REDIRECT; redirect_valid_o is a single-cycle pulse.
- Requests arriving while busy are ignored. Requesters hold them until done_o; a request still high in the IDLE cycle after done_o is accepted again.
- Address arithmetic is modulo 2^XLEN; wrap-around is silent.

Optional Feature:
TRAP_VECTORED_EN
- Defined: if mtvec[1:0] == 2'b01 and cause[31] == 1, target = {mtvec[31:2], 2'b00} + (cause[30:0] << 2). Otherwise target = {mtvec[31:2], 2'b00}.
- Undefined: mtvec[1:0] is always ignored and target = {mtvec[31:2], 2'b00}.

Test Plan:
- Exception with cause = 2, pc = 0x0000_1004, mstatus = 0x0000_0008, mtvec = 0x0000_0100 -> writes mepc = 0x1004, mcause = 2, mstatus = 0x0000_1880; redirect_pc_o = 0x100 eight cycles after accept; done_o pulses once.
- MRET with mepc = 0x1004, mstatus = 0x0000_1880 -> mstatus written 0x0000_1888; redirect_pc_o = 0x1004 six cycles after accept.
- exc_req_i and mret_req_i high on the same edge -> exception sequence runs (first strobe is a write to 0x341); the MRET is accepted after done_o.
- rst_i asserted during WAIT_STAT -> all outputs 0 asynchronously, state IDLE, no redirect; the following exception completes normally.
- With TRAP_VECTORED_EN: mtvec = 0x0000_0201, cause = 0x8000_0007 -> redirect_pc_o = 0x21C. Without the macro -> 0x200.
- Second exc_req_i pulse during busy -> ignored; exactly one redirect_valid_o pulse is observed.
